// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register-bank target.
package i2c_target_regs_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } i2c_state_e;

  localparam logic [7:0] WHOAMI_ADR = 8'h75;
  localparam int         BANK_DEPTH = 16;

  // Decoded bus events, each valid for one MCLK cycle.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;        // synchronized SDA level
  } line_ev_t;

endpackage

// File: rtl/i2c_target_regs_line_cond.sv
// SCL/SDA pad conditioning: 2-flop synchronizers, one history flop, edge and
// START/STOP decode. Bit [1] of each flop pair is SCL, bit [0] is SDA.
module i2c_line_cond
  import i2c_target_regs_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_scl,
  input  logic     i_sda,
  output line_ev_t o_ev
);

  logic [1:0] r_s1, r_s2, r_h;

  // Synchronize both lines; reset to the idle-high bus so no event fires at reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 2'b11;
      r_s2 <= 2'b11;
      r_h  <= 2'b11;
    end else begin
      r_s1 <= {i_scl, i_sda};
      r_s2 <= r_s1;
      r_h  <= r_s2;
    end
  end

  // Compare current synchronized level with history to find edges.
  always_comb begin
    o_ev.scl_rise = r_s2[1] & ~r_h[1];
    o_ev.scl_fall = ~r_s2[1] & r_h[1];
    o_ev.start    = r_s2[1] & r_h[1] & r_h[0] & ~r_s2[0];
    o_ev.stop     = r_s2[1] & r_h[1] & ~r_h[0] & r_s2[0];
    o_ev.sda      = r_s2[0];
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a 16-byte register bank and auto-incrementing pointer.
// SDA updates only on the cycle after a detected SCL fall; SCL is never driven.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [7:0] DEVICE = 8'h68,
  parameter logic [7:0] WHOAMI = 8'h68
) (
  input  logic       i_mclk,
  input  logic       i_reset,
  input  logic       i_scl_in,
  input  logic       i_sda_in,
  output logic       o_sda_out,
  input  logic       i_host_we,
  input  logic [3:0] i_host_adr,
  input  logic [7:0] i_host_din,
  output logic       o_wr_strobe,
  output logic [3:0] o_wr_adr,
  output logic [7:0] o_wr_data,
  output logic       o_busy
);

  line_ev_t   w_ev;
  i2c_state_e r_state, w_state_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_sda, w_sda_nxt;
  logic       r_mack, w_mack_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_bus_we;
  logic [7:0] w_rd_byte;
  logic       r_wr_strobe;
  logic [3:0] r_wr_adr;
  logic [7:0] r_wr_data;
  logic [BANK_DEPTH-1:0][7:0] r_bank;

  i2c_line_cond u_cond (
    .i_clk (i_mclk),
    .i_rst (i_reset),
    .i_scl (i_scl_in),
    .i_sda (i_sda_in),
    .o_ev  (w_ev)
  );

  // Byte presented for a read at the current pointer.
  always_comb begin
    w_rd_byte = 8'h00;
    if (r_ptr < 8'(BANK_DEPTH))   w_rd_byte = r_bank[r_ptr[3:0]];
    else if (r_ptr == WHOAMI_ADR) w_rd_byte = WHOAMI;
  end

  // FSM state register.
  always_ff @(posedge i_mclk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and datapath updates; START/STOP override everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_sda_nxt    = r_sda;
    w_mack_nxt   = r_mack;
    w_busy_nxt   = r_busy;
    w_bus_we     = 1'b0;
    if (w_ev.start) begin
      w_state_nxt  = S_ADDR;
      w_bitcnt_nxt = 4'd0;
      w_sda_nxt    = 1'b1;
      w_busy_nxt   = 1'b1;
    end else if (w_ev.stop) begin
      w_state_nxt = S_IDLE;
      w_sda_nxt   = 1'b1;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_ev.scl_rise) begin
            w_shift_nxt  = {r_shift[6:0], w_ev.sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_ev.scl_fall && r_bitcnt == 4'd8) begin
            w_bitcnt_nxt = 4'd0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == DEVICE[6:0]) begin
                w_state_nxt = S_ADDR_ACK;
                w_sda_nxt   = 1'b0;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end else if (r_state == S_PTR) begin
              w_ptr_nxt   = r_shift;
              w_sda_nxt   = 1'b0;
              w_state_nxt = S_PTR_ACK;
            end else begin
              w_sda_nxt   = 1'b0;
              w_state_nxt = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_ev.scl_fall) begin
            w_bitcnt_nxt = 4'd0;
            if (r_shift[0]) begin
              w_state_nxt = S_RDATA;
              w_shift_nxt = w_rd_byte;
              w_sda_nxt   = w_rd_byte[7];
            end else begin
              w_state_nxt = S_PTR;
              w_sda_nxt   = 1'b1;
            end
          end
        end
        S_PTR_ACK: begin
          if (w_ev.scl_fall) begin
            w_sda_nxt   = 1'b1;
            w_state_nxt = S_WDATA;
          end
        end
        S_WDATA_ACK: begin
          if (w_ev.scl_fall) begin
            w_sda_nxt   = 1'b1;
            w_bus_we    = (r_ptr < 8'(BANK_DEPTH));
            w_ptr_nxt   = r_ptr + 8'd1;
            w_state_nxt = S_WDATA;
          end
        end
        S_RDATA: begin
          if (w_ev.scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_ev.scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_sda_nxt    = 1'b1;
              w_ptr_nxt    = r_ptr + 8'd1;
              w_bitcnt_nxt = 4'd0;
              w_state_nxt  = S_RDATA_ACK;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_sda_nxt   = r_shift[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_ev.scl_rise) begin
            w_mack_nxt = ~w_ev.sda;
          end else if (w_ev.scl_fall) begin
            if (r_mack) begin
              w_state_nxt = S_RDATA;
              w_shift_nxt = w_rd_byte;
              w_sda_nxt   = w_rd_byte[7];
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers and the bus-write report.
  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_ptr       <= 8'h00;
      r_sda       <= 1'b1;
      r_mack      <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_adr    <= 4'd0;
      r_wr_data   <= 8'h00;
    end else begin
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sda       <= w_sda_nxt;
      r_mack      <= w_mack_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_bus_we;
      if (w_bus_we) begin
        r_wr_adr  <= r_ptr[3:0];
        r_wr_data <= r_shift;
      end
    end
  end

  // Register bank; the bus write is applied last so it wins on a same-index collision.
  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      r_bank <= '0;
    end else begin
      if (i_host_we) r_bank[i_host_adr] <= i_host_din;
      if (w_bus_we)  r_bank[r_ptr[3:0]] <= r_shift;
    end
  end

  assign o_sda_out   = r_sda;
  assign o_busy      = r_busy;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_adr    = r_wr_adr;
  assign o_wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master driving the DUT, with a
// byte-level bank/pointer model and a log of observed write strobes.
module tb_i2c_target_regs;

  localparam int Q = 5;   // MCLK cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       host_we = 1'b0;
  logic [3:0] host_adr = 4'd0;
  logic [7:0] host_din = 8'h00;
  logic       o_sda_out, o_wr_strobe, o_busy;
  logic [3:0] o_wr_adr;
  logic [7:0] o_wr_data;

  assign sda_line = sda_m & o_sda_out;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEVICE(8'h68), .WHOAMI(8'h68)) dut (
    .i_mclk      (clk),
    .i_reset     (rst),
    .i_scl_in    (scl_m),
    .i_sda_in    (sda_line),
    .o_sda_out   (o_sda_out),
    .i_host_we   (host_we),
    .i_host_adr  (host_adr),
    .i_host_din  (host_din),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_adr    (o_wr_adr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitors: strobe log, SDA-low count, SDA changes while SCL held high.
  logic [11:0] strobe_log[$];
  int          low_cnt = 0;
  int          hi_chg = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  always @(negedge clk) begin
    if (o_wr_strobe) strobe_log.push_back({o_wr_adr, o_wr_data});
    if (o_sda_out === 1'b0) low_cnt++;
    if (scl_m && prev_scl && (o_sda_out !== prev_sda)) hi_chg++;
    prev_scl = scl_m;
    prev_sda = o_sda_out;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: the bank contents and the pointer.
  logic [7:0] m_bank[16];
  logic [7:0] m_ptr;
  logic [7:0] wbuf[8];

  task automatic m_read(output logic [7:0] v);
    if (m_ptr < 8'd16)       v = m_bank[m_ptr[3:0]];
    else if (m_ptr == 8'h75) v = 8'h68;
    else                     v = 8'h00;
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
    m_ptr = 8'h00;
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_adr = a; host_din = d;
    @(negedge clk);
    host_we = 1'b0;
    m_bank[a] = d;
  endtask

  task automatic bit_cyc(input logic b, output logic s);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    s = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic start_c();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cyc(b[i], s);
    bit_cyc(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic mack, input logic hw, input logic [3:0] ha,
                       input logic [7:0] hd, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cyc(1'b1, s);
      d[i] = s;
      if (hw && i == 6) host_wr(ha, hd);
    end
    bit_cyc(~mack, s);
  endtask

  task automatic tx_write(input logic [7:0] p, input int n);
    logic ack;
    int base;
    logic [11:0] exp[$];
    base = strobe_log.size();
    start_c();
    chk("busy_after_start", o_busy, 1'b1);
    wbyte(8'hD0, ack); chk("wr_addr_ack", ack, 1'b1);
    wbyte(p, ack);     chk("wr_ptr_ack", ack, 1'b1);
    m_ptr = p;
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], ack); chk("wr_data_ack", ack, 1'b1);
      if (m_ptr < 8'd16) begin
        m_bank[m_ptr[3:0]] = wbuf[i];
        exp.push_back({m_ptr[3:0], wbuf[i]});
      end
      m_ptr = m_ptr + 8'd1;
    end
    stop_c(); wq();
    chk("busy_after_stop", o_busy, 1'b0);
    chk("wr_strobe_cnt", strobe_log.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < strobe_log.size()) chk("wr_strobe_val", strobe_log[base+i], exp[i]);
  endtask

  task automatic tx_read(input logic setp, input logic [7:0] p, input int n,
                         input logic hw, input logic [3:0] ha, input logic [7:0] hd);
    logic ack;
    logic [7:0] d, e;
    start_c();
    if (setp) begin
      wbyte(8'hD0, ack); chk("rd_waddr_ack", ack, 1'b1);
      wbyte(p, ack);     chk("rd_ptr_ack", ack, 1'b1);
      m_ptr = p;
      start_c();
    end
    wbyte(8'hD1, ack); chk("rd_addr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      m_read(e);
      rbyte(i < n - 1, hw && i == 0, ha, hd, d);
      chk("rd_data", d, e);
    end
    wq();
    chk("rd_nack_release", o_sda_out, 1'b1);
    stop_c(); wq();
    chk("rd_busy_after_stop", o_busy, 1'b0);
  endtask

  function automatic logic [7:0] pick_ptr();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      16:      return 8'h75;
      17:      return 8'h74;
      18:      return 8'hFF;
      19:      return 8'h40;
      default: return 8'(r);
    endcase
  endfunction

  initial begin
    logic ack, s;
    int base, lows;
    m_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda", o_sda_out, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_strobe", o_wr_strobe, 1'b0);
    chk("rst_wr_adr", o_wr_adr, 4'd0);
    chk("rst_wr_data", o_wr_data, 8'h00);
    wq();

    // Two-byte write from pointer 2.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    tx_write(8'h02, 2);

    // Host-loaded bytes read back over the bus.
    host_wr(4'd0, 8'h12);
    host_wr(4'd1, 8'h34);
    tx_read(1'b1, 8'h00, 2, 1'b0, 4'd0, 8'h00);

    // WHOAMI location.
    tx_read(1'b1, 8'h75, 1, 1'b0, 4'd0, 8'h00);

    // Wrong address: never pulled low, no strobes.
    base = strobe_log.size();
    lows = low_cnt;
    start_c();
    wbyte(8'hD2, ack); chk("bad_addr_ack", ack, 1'b0);
    wbyte(8'h03, ack); chk("bad_addr_byte_ack", ack, 1'b0);
    stop_c(); wq();
    chk("bad_addr_sda_low", low_cnt - lows, 0);
    chk("bad_addr_strobes", strobe_log.size() - base, 0);

    // Write across the top of the bank; pointer continues past it.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    tx_write(8'h0F, 2);
    tx_read(1'b0, 8'h00, 1, 1'b0, 4'd0, 8'h00);    // current address = 0x11
    tx_read(1'b1, 8'h0F, 1, 1'b0, 4'd0, 8'h00);

    // Host write during a read byte must not disturb the byte in flight.
    tx_read(1'b1, 8'h03, 2, 1'b1, 4'd3, 8'hC3);
    tx_read(1'b1, 8'h03, 1, 1'b0, 4'd0, 8'h00);

    // Randomized mix of host writes, bus writes and reads.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) host_wr(4'($urandom_range(0, 15)), 8'($urandom));
      case ($urandom_range(0, 2))
        0: begin
          int n;
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          tx_write(pick_ptr(), n);
        end
        1: tx_read(1'b1, pick_ptr(), $urandom_range(1, 3), 1'b0, 4'd0, 8'h00);
        default: tx_read(1'b0, 8'h00, $urandom_range(1, 3), 1'b0, 4'd0, 8'h00);
      endcase
    end

    // Reset during the 4th bit of a read.
    host_wr(4'd5, 8'h0F);
    start_c();
    wbyte(8'hD0, ack);
    wbyte(8'h05, ack);
    start_c();
    wbyte(8'hD1, ack); chk("mid_rst_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) bit_cyc(1'b1, s);
    sda_m = 1'b1;
    wq();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sda", o_sda_out, 1'b1);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_strobe", o_wr_strobe, 1'b0);
    chk("mid_rst_wr_adr", o_wr_adr, 4'd0);
    chk("mid_rst_wr_data", o_wr_data, 8'h00);
    rst = 1'b0;
    m_reset();
    wq();
    scl_m = 1'b1; wq(); wq();
    chk("post_rst_busy", o_busy, 1'b0);
    tx_read(1'b0, 8'h00, 1, 1'b0, 4'd0, 8'h00);
    wbuf[0] = 8'h9C; wbuf[1] = 8'h4D;
    tx_write(8'h04, 2);
    tx_read(1'b1, 8'h04, 3, 1'b0, 4'd0, 8'h00);

    chk("sda_stable_scl_high", hi_chg, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
